// File: rtl/data_mem_responder.sv
// Multicycle data-memory responder: accepts one load/store at a time and serves it from a
// byte-lane RAM after LATENCY wait cycles. The response is held until the requester takes it.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_ReqValid,
    output logic        o_ReqReady,
    input  logic        i_ReqWrite,
    input  logic [31:0] i_ReqAddr,
    input  logic [31:0] i_ReqWData,
    input  logic [3:0]  i_ReqByteEn,
    output logic        o_RspValid,
    input  logic        i_RspReady,
    output logic [31:0] o_RspRData,
    output logic        o_RspErr
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int AW        = $clog2(DEPTH_WORDS);
    localparam int CW        = 4;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  byteen;
    } req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                          state, state_nxt;
    logic [CW-1:0]                   cnt, cnt_nxt;
    req_t                            req_q, req_nxt;
    rsp_t                            rsp_q, rsp_nxt;
    logic                            addr_err;
    logic                            access;
    logic [AW-1:0]                   word_idx;
    logic [NUM_LANES-1:0]            lane_we;
    logic [NUM_LANES-1:0][VEC_W-1:0] rd_word;

    // Any word-index bit above the RAM depth means out of range.
    assign addr_err = (req_q.addr[1:0] != 2'b00) || (req_q.addr[31:AW+2] != '0);
    assign word_idx = req_q.addr[AW+1:2];
    assign access   = (state == WAIT) && (cnt == '0);
    assign lane_we  = (access && req_q.write && !addr_err) ? req_q.byteen : '0;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [VEC_W-1:0] mem [DEPTH_WORDS];

        always_ff @(posedge i_Clk) begin
            if (lane_we[g]) mem[word_idx] <= req_q.wdata[g*VEC_W +: VEC_W];
        end

        assign rd_word[g] = mem[word_idx];
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_nxt   = req_q;
        rsp_nxt   = rsp_q;
        case (state)
            IDLE: begin
                if (i_ReqValid) begin
                    req_nxt.write  = i_ReqWrite;
                    req_nxt.addr   = i_ReqAddr;
                    req_nxt.wdata  = i_ReqWData;
                    req_nxt.byteen = i_ReqByteEn;
                    cnt_nxt        = CW'(LATENCY - 1);
                    state_nxt      = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt     = RESP;
                    rsp_nxt.err   = addr_err;
                    rsp_nxt.rdata = (req_q.write || addr_err) ? 32'd0 : rd_word;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP: begin
                if (i_RspReady) begin
                    state_nxt = IDLE;
                    rsp_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state <= IDLE;
            cnt   <= '0;
            req_q <= '0;
            rsp_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            req_q <= req_nxt;
            rsp_q <= rsp_nxt;
        end
    end

    assign o_ReqReady = (state == IDLE);
    assign o_RspValid = (state == RESP);
    assign o_RspRData = rsp_q.rdata;
    assign o_RspErr   = rsp_q.err;

endmodule
